// File: rtl/scroll_latch_regs_pkg.sv
// rtl/scroll_latch_regs_pkg.sv - register offsets and width defaults for the scroll register file
// Purpose: register offsets and width defaults shared by the scroll register file
//          and its per-layer counters.
// Ports:   none (package).
package scroll_latch_regs_pkg;

  localparam int HBITS_DEF    = 9;
  localparam int VBITS_DEF    = 8;
  localparam int LAYER_STRIDE = 4;
  localparam int NUM_LAYERS   = 2;

  // Offset within one layer's group of registers (A[1:0]).
  typedef enum logic [1:0] {
    REG_HLO  = 2'd0,
    REG_HHI  = 2'd1,
    REG_V    = 2'd2,
    REG_RSVD = 2'd3
  } reg_off_e;

endpackage

// File: rtl/scroll_counter.sv
// rtl/scroll_counter.sv - active scroll registers and H/V position counters for one layer
// Purpose: holds the committed (active) scroll values of one layer and produces
//          the scrolled horizontal/vertical pixel positions.
// Ports:   clk_i, rst_i           clock, synchronous active-high reset
//          commit_i              copy shadow_h_i/shadow_v_i into the active registers
//          hblank_rise_i         nHBLANK rising edge detected this cycle
//          vblank_rise_i         nVBLANK rising edge detected this cycle
//          hactive_i, vactive_i  current nHBLANK / nVBLANK levels
//          shadow_h_i/shadow_v_i shadow scroll values from the register file
//          hpos_o, vpos_o        registered scrolled positions
module scroll_counter
  import scroll_latch_regs_pkg::*;
#(
  parameter int HBITS = HBITS_DEF,
  parameter int VBITS = VBITS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             commit_i,
  input  logic             hblank_rise_i,
  input  logic             vblank_rise_i,
  input  logic             hactive_i,
  input  logic             vactive_i,
  input  logic [HBITS-1:0] shadow_h_i,
  input  logic [VBITS-1:0] shadow_v_i,
  output logic [HBITS-1:0] hpos_o,
  output logic [VBITS-1:0] vpos_o
);

  logic [HBITS-1:0] act_h_q, act_h_d, hpos_q, hpos_d;
  logic [VBITS-1:0] act_v_q, act_v_d, vpos_q, vpos_d;

  always_comb begin
    act_h_d = act_h_q;
    act_v_d = act_v_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;

    if (commit_i) begin
      act_h_d = shadow_h_i;
      act_v_d = shadow_v_i;
    end

    // Loads take the active value as it stood before any same-cycle commit.
    if (hblank_rise_i)  hpos_d = act_h_q;
    else if (hactive_i) hpos_d = hpos_q + HBITS'(1);

    // Frame start wins over the line step when both edges coincide.
    if (vblank_rise_i)                   vpos_d = act_v_q;
    else if (hblank_rise_i && vactive_i) vpos_d = vpos_q + VBITS'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_h_q <= '0;
      act_v_q <= '0;
      hpos_q  <= '0;
      vpos_q  <= '0;
    end else begin
      act_h_q <= act_h_d;
      act_v_q <= act_v_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
    end
  end

  assign hpos_o = hpos_q;
  assign vpos_o = vpos_q;

endmodule

// File: rtl/scroll_latch_regs.sv
// rtl/scroll_latch_regs.sv - CPU scroll register file with per-frame commit for tile layers 0/1
// Purpose: latches CPU scroll writes into shadow registers, commits them at the
//          start of vertical blank and drives two per-layer scroll counters.
// Ports:   CLK_6M, rst        pixel clock, synchronous active-high reset
//          nLATCH, A, D       write strobe (active-low), register offset, data
//          nHBLANK, nVBLANK   video blanking, active-low
//          HPOS0/1, VPOS0/1   scrolled positions for layer 0/1
//          PENDING            shadow written since the last commit
module scroll_latch_regs
  import scroll_latch_regs_pkg::*;
#(
  parameter int HBITS = HBITS_DEF,
  parameter int VBITS = VBITS_DEF
) (
  input  logic             CLK_6M,
  input  logic             rst,
  input  logic             nLATCH,
  input  logic [2:0]       A,
  input  logic [7:0]       D,
  input  logic             nHBLANK,
  input  logic             nVBLANK,
  output logic [HBITS-1:0] HPOS0,
  output logic [HBITS-1:0] HPOS1,
  output logic [VBITS-1:0] VPOS0,
  output logic [VBITS-1:0] VPOS1,
  output logic             PENDING
);

  logic             nhblank_q, nvblank_q;
  logic             hblank_rise, vblank_rise, commit;
  logic [HBITS-1:0] sh_h_q [NUM_LAYERS];
  logic [HBITS-1:0] sh_h_d [NUM_LAYERS];
  logic [VBITS-1:0] sh_v_q [NUM_LAYERS];
  logic [VBITS-1:0] sh_v_d [NUM_LAYERS];
  logic             pending_q, pending_d;
  logic             wr_layer, wr_en;
  reg_off_e         wr_off;

  assign hblank_rise = nHBLANK & ~nhblank_q;
  assign vblank_rise = nVBLANK & ~nvblank_q;
  assign commit      = ~nVBLANK & nvblank_q;

  assign wr_layer = (A >= 3'(LAYER_STRIDE));
  assign wr_off   = reg_off_e'(A[1:0]);
  assign wr_en    = ~nLATCH & (wr_off != REG_RSVD);

  always_comb begin
    sh_h_d    = sh_h_q;
    sh_v_d    = sh_v_q;
    pending_d = pending_q;
    if (commit) pending_d = 1'b0;
    // A write in the commit cycle lands after the copy, so it stays pending.
    if (wr_en) begin
      pending_d = 1'b1;
      case (wr_off)
        REG_HLO: sh_h_d[wr_layer][7:0]       = D;
        REG_HHI: sh_h_d[wr_layer][HBITS-1:8] = D[HBITS-9:0];
        REG_V:   sh_v_d[wr_layer]            = D[VBITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      nhblank_q <= 1'b1;
      nvblank_q <= 1'b1;
      pending_q <= 1'b0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        sh_h_q[l] <= '0;
        sh_v_q[l] <= '0;
      end
    end else begin
      nhblank_q <= nHBLANK;
      nvblank_q <= nVBLANK;
      pending_q <= pending_d;
      sh_h_q    <= sh_h_d;
      sh_v_q    <= sh_v_d;
    end
  end

  scroll_counter #(.HBITS(HBITS), .VBITS(VBITS)) u_layer0 (
    .clk_i        (CLK_6M),
    .rst_i        (rst),
    .commit_i     (commit),
    .hblank_rise_i(hblank_rise),
    .vblank_rise_i(vblank_rise),
    .hactive_i    (nHBLANK),
    .vactive_i    (nVBLANK),
    .shadow_h_i   (sh_h_q[0]),
    .shadow_v_i   (sh_v_q[0]),
    .hpos_o       (HPOS0),
    .vpos_o       (VPOS0)
  );

  scroll_counter #(.HBITS(HBITS), .VBITS(VBITS)) u_layer1 (
    .clk_i        (CLK_6M),
    .rst_i        (rst),
    .commit_i     (commit),
    .hblank_rise_i(hblank_rise),
    .vblank_rise_i(vblank_rise),
    .hactive_i    (nHBLANK),
    .vactive_i    (nVBLANK),
    .shadow_h_i   (sh_h_q[1]),
    .shadow_v_i   (sh_v_q[1]),
    .hpos_o       (HPOS1),
    .vpos_o       (VPOS1)
  );

  assign PENDING = pending_q;

endmodule

// File: tb/tb_scroll_latch_regs.sv
// tb/tb_scroll_latch_regs.sv - scoreboard bench for scroll_latch_regs
module tb_scroll_latch_regs;

  localparam int HB  = 4;
  localparam int ACT = 8;

  logic       CLK_6M = 1'b0;
  logic       rst, nLATCH, nHBLANK, nVBLANK;
  logic [2:0] A;
  logic [7:0] D;
  logic [8:0] HPOS0, HPOS1;
  logic [7:0] VPOS0, VPOS1;
  logic       PENDING;

  scroll_latch_regs dut (
    .CLK_6M (CLK_6M),
    .rst    (rst),
    .nLATCH (nLATCH),
    .A      (A),
    .D      (D),
    .nHBLANK(nHBLANK),
    .nVBLANK(nVBLANK),
    .HPOS0  (HPOS0),
    .HPOS1  (HPOS1),
    .VPOS0  (VPOS0),
    .VPOS1  (VPOS1),
    .PENDING(PENDING)
  );

  always #5 CLK_6M = ~CLK_6M;

  typedef struct {
    logic [8:0] h0, h1;
    logic [7:0] v0, v1;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state of the frame-based scroll behaviour.
  logic [8:0] m_sh_h[2], m_act_h[2], m_hp[2];
  logic [7:0] m_sh_v[2], m_act_v[2], m_vp[2];
  logic       m_pend, m_hbq, m_vbq;

  logic [8:0] hseq[4];
  logic [7:0] v0_first, v1_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the reference by one clock using the inputs currently driven,
  // queue its outputs, then let the DUT clock and compare.
  task automatic cyc();
    exp_t e;
    bit   hr, vr, vf;
    int   l;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_sh_h[i] = '0; m_act_h[i] = '0; m_hp[i] = '0;
        m_sh_v[i] = '0; m_act_v[i] = '0; m_vp[i] = '0;
      end
      m_pend = 1'b0; m_hbq = 1'b1; m_vbq = 1'b1;
    end else begin
      hr = nHBLANK && !m_hbq;
      vr = nVBLANK && !m_vbq;
      vf = !nVBLANK && m_vbq;
      for (int i = 0; i < 2; i++) begin
        if (hr) m_hp[i] = m_act_h[i];
        else if (nHBLANK) m_hp[i] = m_hp[i] + 9'd1;
        if (vr) m_vp[i] = m_act_v[i];
        else if (hr && nVBLANK) m_vp[i] = m_vp[i] + 8'd1;
        if (vf) begin
          m_act_h[i] = m_sh_h[i];
          m_act_v[i] = m_sh_v[i];
        end
      end
      if (vf) m_pend = 1'b0;
      if (!nLATCH && A[1:0] != 2'd3) begin
        l = int'(A[2]);
        case (A[1:0])
          2'd0:    m_sh_h[l][7:0] = D;
          2'd1:    m_sh_h[l][8]   = D[0];
          default: m_sh_v[l]      = D;
        endcase
        m_pend = 1'b1;
      end
      m_hbq = nHBLANK;
      m_vbq = nVBLANK;
    end
    e.h0 = m_hp[0]; e.h1 = m_hp[1]; e.v0 = m_vp[0]; e.v1 = m_vp[1]; e.p = m_pend;
    sb.push_back(e);
    @(posedge CLK_6M);
    #1;
    e = sb.pop_front();
    check("hpos0", 32'(HPOS0), 32'(e.h0));
    check("hpos1", 32'(HPOS1), 32'(e.h1));
    check("vpos0", 32'(VPOS0), 32'(e.v0));
    check("vpos1", 32'(VPOS1), 32'(e.v1));
    check("pending", 32'(PENDING), 32'(e.p));
  endtask

  // One video line: HB blank cycles then ACT active cycles. A vblank line drops
  // nVBLANK at its start; an active line raises it together with nHBLANK.
  task automatic line(input bit vb, input int wcyc, input logic [2:0] wa,
                      input logic [7:0] wd, input int rcyc);
    nHBLANK = 1'b0;
    if (vb) nVBLANK = 1'b0;
    for (int c = 0; c < HB + ACT; c++) begin
      if (c == HB) begin
        nHBLANK = 1'b1;
        if (!vb) nVBLANK = 1'b1;
      end
      nLATCH = (c == wcyc) ? 1'b0 : 1'b1;
      A      = wa;
      D      = wd;
      rst    = (c == rcyc);
      cyc();
      if (c >= HB && c < HB + 4) hseq[c - HB] = HPOS0;
      if (c == HB) begin
        v0_first = VPOS0;
        v1_first = VPOS1;
      end
    end
    nLATCH = 1'b1;
    rst    = 1'b0;
  endtask

  task automatic idle(input bit vb);
    line(vb, -1, 3'd0, 8'h00, -1);
  endtask

  task automatic wr(input logic [2:0] wa, input logic [7:0] wd);
    line(1'b0, HB + 2, wa, wd, -1);
  endtask

  initial begin
    rst = 1'b1; nLATCH = 1'b1; A = '0; D = '0; nHBLANK = 1'b1; nVBLANK = 1'b1;
    repeat (3) cyc();
    check("rst_hpos0", 32'(HPOS0), 32'h0);
    check("rst_pending", 32'(PENDING), 32'h0);
    rst = 1'b0;

    idle(1'b1); idle(1'b0); idle(1'b0);

    // Reset in the middle of an active line, then counting restarts from 0.
    line(1'b0, -1, 3'd0, 8'h00, HB + 3);
    idle(1'b0);
    check("post_rst_h0_start", 32'(hseq[0]), 32'h0);

    // Write/commit of layer0 hscroll = 0x134.
    wr(3'd0, 8'h34);
    wr(3'd1, 8'h01);
    check("wr_pending", 32'(PENDING), 32'h1);
    idle(1'b0);
    check("h0_uncommitted", 32'(hseq[0]), 32'h0);
    idle(1'b1);
    check("commit_clears_pending", 32'(PENDING), 32'h0);
    idle(1'b1); idle(1'b0);
    check("h0_start_134", 32'(hseq[0]), 32'h134);
    check("h0_next_135", 32'(hseq[1]), 32'h135);

    // Horizontal wrap on layer0 and vertical wrap on layer1.
    wr(3'd0, 8'hFE);
    wr(3'd6, 8'hFE);
    idle(1'b1); idle(1'b1); idle(1'b0);
    check("hwrap0", 32'(hseq[0]), 32'h1FE);
    check("hwrap1", 32'(hseq[1]), 32'h1FF);
    check("hwrap2", 32'(hseq[2]), 32'h000);
    check("hwrap3", 32'(hseq[3]), 32'h001);
    check("v1_line1", 32'(v1_first), 32'hFE);
    idle(1'b0);
    check("v1_line2", 32'(v1_first), 32'hFF);
    idle(1'b0);
    check("v1_line3", 32'(v1_first), 32'h00);

    // Reserved offsets change nothing.
    wr(3'd3, 8'hAA);
    wr(3'd7, 8'hAA);
    check("rsvd_pending", 32'(PENDING), 32'h0);

    // Write in the commit cycle stays in shadow until the following vblank.
    line(1'b1, 0, 3'd2, 8'h55, -1);
    check("simul_pending", 32'(PENDING), 32'h1);
    idle(1'b1); idle(1'b0);
    check("v0_not_55", 32'(v0_first), 32'h00);
    idle(1'b0);
    idle(1'b1);
    check("simul_committed", 32'(PENDING), 32'h0);
    idle(1'b0);
    check("v0_is_55", 32'(v0_first), 32'h55);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
